frame_buf_ctrl: RTL

- Ping-pong scheduler for two BRAM frame banks shared by the camera-side frame writer and the display-side BRAM reader.
- Tracks each bank's ownership, steers the writer to a bank on every end-of-frame, and issues a start pulse to the reader when a completed frame is available.
- Drops frames when the writer outruns the reader.
- Runs a watchdog on the reader so a hung read cannot lock a bank.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_watchdog.sv | 44 ++++
 rtl/frame_buf_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fb_pkg: shared bank-state and reader-FSM encodings for the        |
// | ping-pong frame buffer controller.                                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package fb_pkg;

  typedef logic [1:0] bank_st_t;

  localparam bank_st_t FREE    = 2'd0;
  localparam bank_st_t WRITING = 2'd1;
  localparam bank_st_t FULL    = 2'd2;
  localparam bank_st_t READING = 2'd3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rd_state_e;

  function automatic logic other_bank(input logic b);
    return ~b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_watchdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fb_watchdog: clear/enable cycle counter with a terminal-count     |
// | flag at TIMEOUT_CYCLES-1.                                         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over enable so the count is zero on the first active cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = i_en && (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/frame_buf_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_buf_ctrl: ping-pong ownership scheduler for two BRAM frame  |
// | banks shared by a frame writer and a frame reader.                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module frame_buf_ctrl
  import fb_pkg::*;
#(
  parameter int BRAM_DEPTH     = 16384,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr_eof,
  input  logic             i_rd_ready,
  input  logic             i_rd_done,
  output logic             o_wr_bank,
  output logic             o_rd_bank,
  output logic             o_rd_req,
  output logic             o_rd_busy,
  output logic             o_frame_drop,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_frames_out,
  output logic             o_timeout
);

  if (TIMEOUT_CYCLES < 2 || BRAM_DEPTH < 1) begin : g_param_check
    $error("frame_buf_ctrl: TIMEOUT_CYCLES must be >= 2 and BRAM_DEPTH >= 1");
  end

  bank_st_t [1:0]   bank_q;
  bank_st_t [1:0]   bank_d;
  rd_state_e        state_q;
  rd_state_e        state_d;
  logic             wr_bank_q;
  logic             wr_bank_d;
  logic             rd_bank_q;
  logic             rd_bank_d;
  logic             rd_req_q;
  logic             rd_req_d;
  logic             drop_q;
  logic             drop_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;
  logic [CNT_W-1:0] frames_q;
  logic [CNT_W-1:0] frames_d;

  logic w_other;
  logic w_launch;
  logic w_launch_bank;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_tc;

  assign w_other       = other_bank(wr_bank_q);
  assign w_launch_bank = (bank_q[1] == FULL);
  assign w_launch      = (state_q == IDLE) && i_en && i_rd_ready &&
                         ((bank_q[0] == FULL) || (bank_q[1] == FULL));

  assign w_wd_en  = (state_q == ACTIVE);
  assign w_wd_clr = (state_q == IDLE) || i_rd_done || w_wd_tc;

  fb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_wd_clr),
    .i_en  (w_wd_en),
    .o_tc  (w_wd_tc)
  );

  always_comb begin
    bank_d     = bank_q;
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_req_d   = 1'b0;
    drop_d     = 1'b0;
    timeout_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;
    frames_d   = frames_q;

    case (state_q)
      IDLE: begin
        if (w_launch) begin
          bank_d[w_launch_bank] = READING;
          rd_bank_d             = w_launch_bank;
          rd_req_d              = 1'b1;
          state_d               = ACTIVE;
        end
      end
      ACTIVE: begin
        if (i_rd_done) begin
          bank_d[rd_bank_q] = FREE;
          frames_d          = frames_q + CNT_W'(1);
          state_d           = IDLE;
        end else if (w_wd_tc) begin
          bank_d[rd_bank_q] = FREE;
          timeout_d         = 1'b1;
          state_d           = IDLE;
        end
      end
    endcase

    // The other bank counts as READING if it is being read at cycle start
    // or is claimed by a launch in this same cycle.
    if (i_wr_eof) begin
      if ((bank_q[w_other] == READING) || (w_launch && (w_launch_bank == w_other))) begin
        drop_d = 1'b1;
      end else begin
        drop_d            = (bank_q[w_other] == FULL);
        bank_d[wr_bank_q] = FULL;
        bank_d[w_other]   = WRITING;
        wr_bank_d         = w_other;
      end
    end

    if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bank_q[0]  <= WRITING;
      bank_q[1]  <= FREE;
      state_q    <= IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_req_q   <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      drop_cnt_q <= '0;
      frames_q   <= '0;
    end else begin
      bank_q     <= bank_d;
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_req_q   <= rd_req_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
      drop_cnt_q <= drop_cnt_d;
      frames_q   <= frames_d;
    end
  end

  assign o_wr_bank    = wr_bank_q;
  assign o_rd_bank    = rd_bank_q;
  assign o_rd_req     = rd_req_q;
  assign o_rd_busy    = (state_q == ACTIVE);
  assign o_frame_drop = drop_q;
  assign o_drop_cnt   = drop_cnt_q;
  assign o_frames_out = frames_q;
  assign o_timeout    = timeout_q;

endmodule
`default_nettype wire
